id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage with its ID/EXE pipeline register built in. Block contents:
- condition check against the status flags
- control-unit decode
- register file with write-through bypass
- source/two-source reporting for the hazard unit
All decoded fields are registered into the EXE stage with freeze (hold) and flush (bubble) control. Sits between the IF/ID register and the EXE stage; the WB stage drives the register-file write port.

Parameters:
DATA_W, 32, datapath / register width
NREGS, 16, number of architectural registers (power of two)
REG_AW, 4, register address width = log2(NREGS)
PC_W, 32, program counter width
BYPASS, 1, 1 = same-cycle WB write is forwarded to the read ports; 0 = read returns the old value

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instr  in  32  instruction from the IF/ID register
pc_in  in  PC_W  PC of instr
wb_en_in  in  1  WB register write enable
wb_dest  in  REG_AW  WB destination register
wb_value  in  DATA_W  WB write data
hazard  in  1  insert bubble (stall from hazard unit)
freeze  in  1  hold the output register
flush  in  1  branch taken: squash
sr  in  4  status flags {N,Z,C,V}
src1  out  REG_AW  Rn index (combinational)
src2  out  REG_AW  Rm, or Rd on store (combinational)
two_src  out  1  ~I | mem_w (combinational)
valid_o, wb_en_o, mem_r_o, mem_w_o, b_o, s_o  out  1 each  registered control
exe_cmd_o  out  4  registered ALU command
val_rn_o, val_rm_o  out  DATA_W  registered operands
imm_o  out  1  registered I bit
shift_op_o  out  12  registered instr[11:0]
simm24_o  out  24  registered instr[23:0]
dest_o  out  REG_AW  registered instr[15:12] (low REG_AW bits)
pc_o  out  PC_W  registered pc_in

Behaviour:
- Reset (synchronous): all registered outputs are 0 and all NREGS registers are 0.
- Latency: 1 cycle, instr to registered outputs.
- Condition check, on cond = instr[31:28]:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE use the standard ARM flag equations.
  - AL (1110) passes.
  - 1111 fails.
- Decode by mode = instr[27:26], op = instr[24:21], S = instr[20]:
  - mode 00, data processing (op -> exe_cmd):
    - MOV 1101 -> 0001; MVN 1111 -> 1001; ADD 0100 -> 0010; ADC 0101 -> 0011
    - SUB 0010 -> 0100; SBC 0110 -> 0101; AND 0000 -> 0110; ORR 1100 -> 0111; EOR 0001 -> 1000
    - wb_en = 1, s = S.
    - CMP 1010 -> 0100 and TST 1000 -> 0110 with wb_en = 0, s = 1.
    - Any other op gives a NOP: all control 0.
  - mode 01: exe_cmd = 0010.
    - S = 1 is LDR: mem_r = 1, wb_en = 1.
    - S = 0 is STR: mem_w = 1.
  - mode 10: b = 1.
  - mode 11: NOP.
- Kill: kill = ~cond_ok | hazard. When kill = 1, wb_en, mem_r, mem_w, b, s and exe_cmd are forced to 0 and valid is 0.
- Register file:
  - NREGS x DATA_W, two asynchronous reads (src1, src2), one synchronous write on posedge when wb_en_in = 1.
  - BYPASS = 1: a read whose index equals wb_dest while wb_en_in = 1 returns wb_value in the same cycle.
- Output register update priority: rst > flush > freeze > load.
  - flush: load a bubble (all control and valid 0; data fields don't-care, implemented as 0).
  - freeze: hold every output.
  - load: capture the decoded fields.
  - flush and freeze together: flush wins.
- The register-file write proceeds regardless of freeze, flush or hazard. It is blocked only by rst.
- simm24_o is the raw 24-bit field. Sign extension to the branch offset is done in EXE.
- src1, src2 and two_src reflect the current instr even while freeze or hazard is asserted.

Decomposition:
- Shared package arm_pkg holds:
  - exe_cmd localparams (CMD_MOV, CMD_ADD, ...)
  - opcode localparams
  - cond-code localparams
  - mode encodings
- Natural sub-module: reg_file_bypass (NREGS, DATA_W, BYPASS).
- Condition check and control decode stay as combinational always-blocks inside id_stage_pipe.

Test Plan:
- Reset sequence → all outputs 0; reading R0..R15 returns 0.
- WB writes R3 = 32'hDEADBEEF while instr = ADD R1,R3,R4 with BYPASS = 1 → next cycle val_rn_o = 32'hDEADBEEF, exe_cmd_o = 0010, wb_en_o = 1. With BYPASS = 0 → val_rn_o = 0.
- instr = SUBEQ with sr.Z = 0 → valid_o = 0 and all control 0. Same instr with Z = 1 → exe_cmd_o = 0100, valid_o = 1.
- STR R2,[R5] → src2 = 2, two_src = 1, mem_w_o = 1, wb_en_o = 0. CMP with I = 1 → two_src = 0, s_o = 1, wb_en_o = 0.
- freeze held 3 cycles while instr changes → outputs unchanged. Then flush and freeze together → valid_o = 0, b_o = 0 next cycle.
- hazard = 1 on LDR → bubble registered, while a WB write to R7 during the same cycle still lands (verified by a later read of R7).

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-style decode stage: ALU commands, opcodes,
// condition codes, instruction modes and the decoded control bundle.
package arm_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic [3:0] cmd;
  } ctrl_t;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file: NREGS x DATA_W, two async reads, one sync write, sync reset.
// Ports: i_we/i_wa/i_wd write port; i_ra1/i_ra2 -> o_rd1/o_rd2 read ports.
module reg_file_bypass #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_hit1;
  logic              w_hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++)
        r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // A same-cycle write shows up on the read port only when bypass is built.
  assign w_hit1 = BYPASS && i_we && (i_wa == i_ra1);
  assign w_hit2 = BYPASS && i_we && (i_wa == i_ra2);

  assign o_rd1 = w_hit1 ? i_wd : r_mem[i_ra1];
  assign o_rd2 = w_hit2 ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with built-in ID/EXE register: cond check, control decode,
// bypassed register file, hazard sources; outputs registered, 1-cycle latency.
module id_stage_pipe
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int REG_AW = 4,
  parameter int PC_W   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              hazard,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        sr,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic              two_src,
  output logic              valid_o,
  output logic              wb_en_o,
  output logic              mem_r_o,
  output logic              mem_w_o,
  output logic              b_o,
  output logic              s_o,
  output logic [3:0]        exe_cmd_o,
  output logic [DATA_W-1:0] val_rn_o,
  output logic [DATA_W-1:0] val_rm_o,
  output logic              imm_o,
  output logic [11:0]       shift_op_o,
  output logic [23:0]       simm24_o,
  output logic [REG_AW-1:0] dest_o,
  output logic [PC_W-1:0]   pc_o
);

  logic [3:0]  w_cond;
  logic [1:0]  w_mode;
  logic [3:0]  w_op;
  logic        w_sbit;
  logic        w_ibit;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ok;
  logic        w_kill;
  logic        w_dp;
  ctrl_t       w_dec;
  ctrl_t       w_ctl;
  logic [DATA_W-1:0] w_rn;
  logic [DATA_W-1:0] w_rm;

  assign w_cond = instr[31:28];
  assign w_mode = instr[27:26];
  assign w_ibit = instr[25];
  assign w_op   = instr[24:21];
  assign w_sbit = instr[20];
  assign {w_n, w_z, w_c, w_v} = sr;

  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      COND_EQ: w_cond_ok = w_z;
      COND_NE: w_cond_ok = ~w_z;
      COND_CS: w_cond_ok = w_c;
      COND_CC: w_cond_ok = ~w_c;
      COND_MI: w_cond_ok = w_n;
      COND_PL: w_cond_ok = ~w_n;
      COND_VS: w_cond_ok = w_v;
      COND_VC: w_cond_ok = ~w_v;
      COND_HI: w_cond_ok = w_c & ~w_z;
      COND_LS: w_cond_ok = ~w_c | w_z;
      COND_GE: w_cond_ok = (w_n == w_v);
      COND_LT: w_cond_ok = (w_n != w_v);
      COND_GT: w_cond_ok = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ok = w_z | (w_n != w_v);
      COND_AL: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_dec = '0;
    w_dp  = 1'b0;
    case (w_mode)
      MODE_DP: begin
        case (w_op)
          OP_MOV: begin w_dec.cmd = CMD_MOV; w_dp = 1'b1; end
          OP_MVN: begin w_dec.cmd = CMD_MVN; w_dp = 1'b1; end
          OP_ADD: begin w_dec.cmd = CMD_ADD; w_dp = 1'b1; end
          OP_ADC: begin w_dec.cmd = CMD_ADC; w_dp = 1'b1; end
          OP_SUB: begin w_dec.cmd = CMD_SUB; w_dp = 1'b1; end
          OP_SBC: begin w_dec.cmd = CMD_SBC; w_dp = 1'b1; end
          OP_AND: begin w_dec.cmd = CMD_AND; w_dp = 1'b1; end
          OP_ORR: begin w_dec.cmd = CMD_ORR; w_dp = 1'b1; end
          OP_EOR: begin w_dec.cmd = CMD_EOR; w_dp = 1'b1; end
          OP_CMP: begin w_dec.cmd = CMD_SUB; w_dec.s = 1'b1; end
          OP_TST: begin w_dec.cmd = CMD_AND; w_dec.s = 1'b1; end
          default: w_dec = '0;
        endcase
        if (w_dp) begin
          w_dec.wb_en = 1'b1;
          w_dec.s     = w_sbit;
        end
      end
      MODE_MEM: begin
        w_dec.cmd   = CMD_ADD;
        w_dec.mem_r = w_sbit;
        w_dec.wb_en = w_sbit;
        w_dec.mem_w = ~w_sbit;
      end
      MODE_BR: w_dec.b = 1'b1;
      default: w_dec = '0;
    endcase
  end

  assign w_kill = ~w_cond_ok | hazard;
  assign w_ctl  = w_kill ? '0 : w_dec;

  // Hazard sources follow the raw instruction, independent of kill/freeze.
  assign src1    = instr[16 +: REG_AW];
  assign src2    = w_dec.mem_w ? instr[12 +: REG_AW] : instr[0 +: REG_AW];
  assign two_src = ~w_ibit | w_dec.mem_w;

  reg_file_bypass #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_en_in),
    .i_wa  (wb_dest),
    .i_wd  (wb_value),
    .i_ra1 (src1),
    .i_ra2 (src2),
    .o_rd1 (w_rn),
    .o_rd2 (w_rm)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_o    <= 1'b0;
      wb_en_o    <= 1'b0;
      mem_r_o    <= 1'b0;
      mem_w_o    <= 1'b0;
      b_o        <= 1'b0;
      s_o        <= 1'b0;
      exe_cmd_o  <= '0;
      val_rn_o   <= '0;
      val_rm_o   <= '0;
      imm_o      <= 1'b0;
      shift_op_o <= '0;
      simm24_o   <= '0;
      dest_o     <= '0;
      pc_o       <= '0;
    end else if (!freeze) begin
      valid_o    <= ~w_kill;
      wb_en_o    <= w_ctl.wb_en;
      mem_r_o    <= w_ctl.mem_r;
      mem_w_o    <= w_ctl.mem_w;
      b_o        <= w_ctl.b;
      s_o        <= w_ctl.s;
      exe_cmd_o  <= w_ctl.cmd;
      val_rn_o   <= w_rn;
      val_rm_o   <= w_rm;
      imm_o      <= w_ibit;
      shift_op_o <= instr[11:0];
      simm24_o   <= instr[23:0];
      dest_o     <= instr[12 +: REG_AW];
      pc_o       <= pc_in;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed cases then random traffic,
// checked against a table-driven reference model (BYPASS=1 and BYPASS=0).
module tb_id_stage_pipe;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] rn0;
    logic [31:0] rm0;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        wb_en_in;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        hazard;
  logic        freeze;
  logic        flush;
  logic [3:0]  sr;

  logic [3:0]  a_src1, a_src2, a_dest;
  logic        a_two, a_valid, a_wb, a_mr, a_mw, a_b, a_s, a_imm;
  logic [3:0]  a_cmd;
  logic [31:0] a_rn, a_rm, a_pc;
  logic [11:0] a_sh;
  logic [23:0] a_simm;

  logic [3:0]  b_src1, b_src2, b_dest;
  logic        b_two, b_valid, b_wb, b_mr, b_mw, b_b, b_s, b_imm;
  logic [3:0]  b_cmd;
  logic [31:0] b_rn, b_rm, b_pc;
  logic [11:0] b_sh;
  logic [23:0] b_simm;

  id_stage_pipe #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .hazard(hazard), .freeze(freeze), .flush(flush), .sr(sr),
    .src1(a_src1), .src2(a_src2), .two_src(a_two),
    .valid_o(a_valid), .wb_en_o(a_wb), .mem_r_o(a_mr), .mem_w_o(a_mw),
    .b_o(a_b), .s_o(a_s), .exe_cmd_o(a_cmd),
    .val_rn_o(a_rn), .val_rm_o(a_rm), .imm_o(a_imm),
    .shift_op_o(a_sh), .simm24_o(a_simm), .dest_o(a_dest), .pc_o(a_pc)
  );

  id_stage_pipe #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .hazard(hazard), .freeze(freeze), .flush(flush), .sr(sr),
    .src1(b_src1), .src2(b_src2), .two_src(b_two),
    .valid_o(b_valid), .wb_en_o(b_wb), .mem_r_o(b_mr), .mem_w_o(b_mw),
    .b_o(b_b), .s_o(b_s), .exe_cmd_o(b_cmd),
    .val_rn_o(b_rn), .val_rm_o(b_rm), .imm_o(b_imm),
    .shift_op_o(b_sh), .simm24_o(b_simm), .dest_o(b_dest), .pc_o(b_pc)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t cur;
  logic [31:0] rf[16];
  // Data-processing opcode -> ALU command, -1 marks an unsupported opcode.
  int dp_cmd[16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  function automatic void chk(string n, logic [63:0] act, logic [63:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, ex, $time);
    end
  endfunction

  function automatic logic cond_pass(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd(logic [3:0] idx, bit byp);
    if (byp && wb_en_in && wb_dest == idx) return wb_value;
    return rf[idx];
  endfunction

  function automatic logic is_store(logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  function automatic logic [3:0] ref_src2(logic [31:0] ins);
    return is_store(ins) ? ins[15:12] : ins[3:0];
  endfunction

  function automatic exp_t load_model(logic [31:0] ins, logic hz);
    exp_t e;
    int   op;
    e  = '0;
    op = int'(ins[24:21]);
    if (cond_pass(ins[31:28], sr) && !hz) begin
      e.valid = 1'b1;
      if (ins[27:26] == 2'b00 && dp_cmd[op] >= 0) begin
        e.cmd = 4'(dp_cmd[op]);
        if (op == 8 || op == 10) e.s = 1'b1;
        else begin e.wb = 1'b1; e.s = ins[20]; end
      end else if (ins[27:26] == 2'b01) begin
        e.cmd = 4'd2;
        e.mr = ins[20]; e.wb = ins[20]; e.mw = !ins[20];
      end else if (ins[27:26] == 2'b10) begin
        e.b = 1'b1;
      end
    end
    e.rn   = rd(ins[19:16], 1);
    e.rm   = rd(ref_src2(ins), 1);
    e.rn0  = rd(ins[19:16], 0);
    e.rm0  = rd(ref_src2(ins), 0);
    e.imm  = ins[25];
    e.sh   = ins[11:0];
    e.simm = ins[23:0];
    e.dest = ins[15:12];
    e.pc   = pc_in;
    return e;
  endfunction

  task automatic step(logic [31:0] ins, logic we, logic [3:0] wd,
                      logic [31:0] wv, logic hz, logic fz, logic fl,
                      logic r, logic [3:0] f);
    instr = ins; pc_in = $urandom; wb_en_in = we; wb_dest = wd;
    wb_value = wv; hazard = hz; freeze = fz; flush = fl; rst = r; sr = f;
    #1;
    chk("src1", 64'({a_src1, b_src1}), 64'({ins[19:16], ins[19:16]}));
    chk("src2", 64'({a_src2, b_src2}), 64'({2{ref_src2(ins)}}));
    chk("two_src", 64'({a_two, b_two}),
        64'({2{!ins[25] || is_store(ins)}}));
    if (r || fl) cur = '0;
    else if (!fz) cur = load_model(ins, hz);
    q.push_back(cur);
    if (r) foreach (rf[k]) rf[k] = '0;
    else if (we) rf[wd] = wv;
    @(negedge clk);
  endtask

  function automatic logic [31:0] dp(logic [3:0] c, logic i, logic [3:0] op,
                                     logic s, logic [3:0] rn, logic [3:0] rdd,
                                     logic [11:0] sh);
    return {c, 2'b00, i, op, s, rn, rdd, sh};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", 64'({a_valid, a_wb, a_mr, a_mw, a_b, a_s, a_cmd}),
            64'({e.valid, e.wb, e.mr, e.mw, e.b, e.s, e.cmd}));
        chk("ctrl_nb", 64'({b_valid, b_wb, b_mr, b_mw, b_b, b_s, b_cmd}),
            64'({e.valid, e.wb, e.mr, e.mw, e.b, e.s, e.cmd}));
        chk("val_rn_rm", {a_rn, a_rm}, {e.rn, e.rm});
        chk("val_rn_rm_nb", {b_rn, b_rm}, {e.rn0, e.rm0});
        chk("fields", 64'({a_imm, a_sh, a_simm, a_dest}),
            64'({e.imm, e.sh, e.simm, e.dest}));
        chk("fields_nb", 64'({b_imm, b_sh, b_simm, b_dest}),
            64'({e.imm, e.sh, e.simm, e.dest}));
        chk("pc", {a_pc, b_pc}, {e.pc, e.pc});
      end
    end
  end

  initial begin : driver
    logic [31:0] ins;
    logic [3:0]  f;
    int          w;
    instr = '0; pc_in = '0; wb_en_in = 0; wb_dest = '0; wb_value = '0;
    hazard = 0; freeze = 0; flush = 0; sr = '0; rst = 1;
    cur = '0;
    foreach (rf[k]) rf[k] = '0;
    @(negedge clk);
    step(32'h0, 1, 4'd5, 32'h1234, 0, 0, 0, 1, 4'h0);
    step(32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 4'h0);
    for (int i = 0; i < 16; i++)
      step(dp(4'hE, 0, 4'b1101, 0, 4'(i), 4'(i), 12'(i)),
           0, 0, 0, 0, 0, 0, 0, 4'h0);
    // ADD R1,R3,R4 while WB writes R3
    step(dp(4'hE, 0, 4'b0100, 0, 4'd3, 4'd1, 12'd4),
         1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 4'h0);
    // SUBEQ with Z=0 then Z=1
    step(dp(4'h0, 0, 4'b0010, 0, 4'd3, 4'd2, 12'd1),
         0, 0, 0, 0, 0, 0, 0, 4'b0000);
    step(dp(4'h0, 0, 4'b0010, 0, 4'd3, 4'd2, 12'd1),
         0, 0, 0, 0, 0, 0, 0, 4'b0100);
    // STR R2,[R5] then CMP with I=1
    step({4'hE, 2'b01, 1'b0, 4'b1100, 1'b0, 4'd5, 4'd2, 12'd0},
         1, 4'd2, 32'h55AA, 0, 0, 0, 0, 4'h0);
    step(dp(4'hE, 1, 4'b1010, 1, 4'd3, 4'd0, 12'h0FF),
         0, 0, 0, 0, 0, 0, 0, 4'h0);
    // freeze for three cycles on changing instructions, then flush+freeze
    step(dp(4'hE, 0, 4'b0000, 1, 4'd1, 4'd2, 12'd3),
         0, 0, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++)
      step($urandom, 0, 0, 0, 0, 1, 0, 0, 4'($urandom));
    step({4'hE, 2'b10, 26'h3ABCDE}, 0, 0, 0, 0, 1, 1, 0, 4'h0);
    // hazard on LDR while WB writes R7, then read R7 back
    step({4'hE, 2'b01, 1'b0, 4'b1100, 1'b1, 4'd7, 4'd9, 12'd0},
         1, 4'd7, 32'hCAFEF00D, 1, 0, 0, 0, 4'h0);
    step(dp(4'hE, 0, 4'b0100, 0, 4'd7, 4'd1, 12'd7),
         0, 0, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[31:28] = 4'hE;
      f = 4'($urandom);
      w = $urandom_range(99);
      step(ins, 1'($urandom), 4'($urandom), $urandom,
           $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(9) == 0, w < 2, f);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
